// File: rtl/jtkcpu_bra_pkg.sv
// Shared KONAMI-1 branch encodings: opcodes, CC bit indices and sequencer state codes.
// Mirrors the jtkcpu.inc definitions so the branch sequencer can be built standalone.
package jtkcpu_bra_pkg;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    // Condition-code bit indices
    localparam int unsigned CC_C = 0;
    localparam int unsigned CC_V = 1;
    localparam int unsigned CC_Z = 2;
    localparam int unsigned CC_N = 3;
    localparam int unsigned CC_I = 4;
    localparam int unsigned CC_H = 5;
    localparam int unsigned CC_F = 6;
    localparam int unsigned CC_E = 7;

    // Short branches occupy 0x20-0x2F, long conditional branches 0x30-0x3F
    localparam logic [DW-1:0] OP_BRA  = 8'h20;
    localparam logic [DW-1:0] OP_BRN  = 8'h21;
    localparam logic [DW-1:0] OP_BHI  = 8'h22;
    localparam logic [DW-1:0] OP_BLS  = 8'h23;
    localparam logic [DW-1:0] OP_BCC  = 8'h24;
    localparam logic [DW-1:0] OP_BCS  = 8'h25;
    localparam logic [DW-1:0] OP_BNE  = 8'h26;
    localparam logic [DW-1:0] OP_BEQ  = 8'h27;
    localparam logic [DW-1:0] OP_BVC  = 8'h28;
    localparam logic [DW-1:0] OP_BVS  = 8'h29;
    localparam logic [DW-1:0] OP_BPL  = 8'h2A;
    localparam logic [DW-1:0] OP_BMI  = 8'h2B;
    localparam logic [DW-1:0] OP_BGE  = 8'h2C;
    localparam logic [DW-1:0] OP_BLT  = 8'h2D;
    localparam logic [DW-1:0] OP_BGT  = 8'h2E;
    localparam logic [DW-1:0] OP_BLE  = 8'h2F;
    localparam logic [DW-1:0] OP_LBRN = 8'h31;
    localparam logic [DW-1:0] OP_LBNE = 8'h36;
    localparam logic [DW-1:0] OP_LBEQ = 8'h37;
    localparam logic [DW-1:0] OP_LBRA = 8'h16;
    localparam logic [DW-1:0] OP_LBSR = 8'h17;
    localparam logic [DW-1:0] OP_BSR  = 8'h8D;

    // Sequencer state encodings
    localparam logic [2:0] BRA_IDLE     = 3'd0;
    localparam logic [2:0] BRA_FETCH_HI = 3'd1;
    localparam logic [2:0] BRA_FETCH_LO = 3'd2;
    localparam logic [2:0] BRA_CALC     = 3'd3;
    localparam logic [2:0] BRA_PUSH_LO  = 3'd4;
    localparam logic [2:0] BRA_PUSH_HI  = 3'd5;
    localparam logic [2:0] BRA_FINISH   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = BRA_IDLE,
        ST_FETCH_HI = BRA_FETCH_HI,
        ST_FETCH_LO = BRA_FETCH_LO,
        ST_CALC     = BRA_CALC,
        ST_PUSH_LO  = BRA_PUSH_LO,
        ST_PUSH_HI  = BRA_PUSH_HI,
        ST_FINISH   = BRA_FINISH
    } bra_state_e;

    function automatic logic is_long(input logic [DW-1:0] op);
        return (op[7:4] == 4'h3) || (op == OP_LBRA) || (op == OP_LBSR);
    endfunction

    function automatic logic is_bsr(input logic [DW-1:0] op);
        return (op == OP_BSR) || (op == OP_LBSR);
    endfunction

endpackage

// File: rtl/jtkcpu_bra_add.sv
// Combinational return-address and branch-target adder with short-offset sign extension.
module jtkcpu_bra_add
    import jtkcpu_bra_pkg::*;
(
    input  logic [15:0] pc,
    input  logic        long_op,
    input  logic        taken,
    input  logic [15:0] off,
    output logic [15:0] ret,
    output logic [15:0] target
);

    logic [15:0] off_ext;

    // Short branches carry a signed 8-bit displacement in the low byte only
    always_comb begin
        off_ext = long_op ? off : {{8{off[7]}}, off[7:0]};
        ret     = pc + (long_op ? 16'd2 : 16'd1);
        target  = taken ? 16'(ret + off_ext) : ret;
    end

endmodule

// File: rtl/jtkcpu_bra_seq.sv
// Branch execution sequencer: offset fetch, PC update and BSR/LBSR return-address push.
// Optional macro JTKCPU_BRA_FASTPATH_EN: short untaken branches skip the offset read.
module jtkcpu_bra_seq
    import jtkcpu_bra_pkg::*;
(
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic        branch,
    input  logic [15:0] pc,
    input  logic [15:0] s,
    input  logic [7:0]  din,
    input  logic        bus_ack,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        pc_we,
    output logic [15:0] pc_nxt,
    output logic        s_we,
    output logic [15:0] s_nxt,
    output logic        busy,
    output logic        done
);

    bra_state_e  state;
    logic [7:0]  op_q;
    logic [15:0] pc_q;
    logic [15:0] s_q;
    logic        taken_q;
    logic [15:0] off_q;
    logic [15:0] ret;
    logic [15:0] target;
    logic        long_q;
    logic        bsr_q;

    assign long_q = is_long(op_q);
    assign bsr_q  = is_bsr(op_q);

    jtkcpu_bra_add u_add (
        .pc      (pc_q),
        .long_op (long_q),
        .taken   (taken_q),
        .off     (off_q),
        .ret     (ret),
        .target  (target)
    );

    // Single registered FSM; strobes clear on the next enabled cycle so they last one cen cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_q    <= 8'd0;
            pc_q    <= 16'd0;
            s_q     <= 16'd0;
            taken_q <= 1'b0;
            off_q   <= 16'd0;
            bus_rd  <= 1'b0;
            bus_wr  <= 1'b0;
            addr    <= 16'd0;
            dout    <= 8'd0;
            pc_we   <= 1'b0;
            pc_nxt  <= 16'd0;
            s_we    <= 1'b0;
            s_nxt   <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (cen) begin
            pc_we <= 1'b0;
            s_we  <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        pc_q    <= pc;
                        s_q     <= s;
                        taken_q <= branch;
                        off_q   <= 16'd0;
                        busy    <= 1'b1;
                        if (is_long(op)) begin
                            state  <= ST_FETCH_HI;
                            bus_rd <= 1'b1;
                            addr   <= pc;
                        end
`ifdef JTKCPU_BRA_FASTPATH_EN
                        else if (!branch) begin
                            state <= ST_CALC;
                        end
`endif
                        else begin
                            state  <= ST_FETCH_LO;
                            bus_rd <= 1'b1;
                            addr   <= pc;
                        end
                    end
                end
                ST_FETCH_HI: begin
                    if (bus_ack) begin
                        off_q[15:8] <= din;
                        addr        <= 16'(pc_q + 16'd1);
                        state       <= ST_FETCH_LO;
                    end
                end
                ST_FETCH_LO: begin
                    if (bus_ack) begin
                        off_q[7:0] <= din;
                        bus_rd     <= 1'b0;
                        state      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    pc_we  <= 1'b1;
                    pc_nxt <= target;
                    if (bsr_q) begin
                        state  <= ST_PUSH_LO;
                        bus_wr <= 1'b1;
                        addr   <= 16'(s_q - 16'd1);
                        dout   <= ret[7:0];
                    end else begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                    end
                end
                ST_PUSH_LO: begin
                    if (bus_ack) begin
                        addr  <= 16'(s_q - 16'd2);
                        dout  <= ret[15:8];
                        state <= ST_PUSH_HI;
                    end
                end
                ST_PUSH_HI: begin
                    if (bus_ack) begin
                        bus_wr <= 1'b0;
                        s_we   <= 1'b1;
                        s_nxt  <= 16'(s_q - 16'd2);
                        done   <= 1'b1;
                        state  <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    bus_rd <= 1'b0;
                    bus_wr <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtkcpu_bra_seq.sv
// Scoreboard bench for jtkcpu_bra_seq: a bus responder logs transactions and strobes,
// each test task pushes its expected results and compares them against the logs.
module tb_jtkcpu_bra_seq;
    import jtkcpu_bra_pkg::*;

    logic        rst, clk, cen, start, branch, bus_ack;
    logic [7:0]  op, din, dout;
    logic [15:0] pc, s, addr, pc_nxt, s_nxt;
    logic        bus_rd, bus_wr, pc_we, s_we, busy, done;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t        exp_bus[$], act_bus[$];
    logic [15:0] exp_pc[$], act_pc[$], exp_s[$], act_s[$];
    logic [7:0]  mem [0:65535];

    int          checks, errors, done_cnt, ack_delay, wcnt;
    bit          cen_toggle, wr_stall, hold;
    logic [15:0] prev_addr;

    jtkcpu_bra_seq dut (
        .rst     (rst),
        .clk     (clk),
        .cen     (cen),
        .start   (start),
        .op      (op),
        .branch  (branch),
        .pc      (pc),
        .s       (s),
        .din     (din),
        .bus_ack (bus_ack),
        .bus_rd  (bus_rd),
        .bus_wr  (bus_wr),
        .addr    (addr),
        .dout    (dout),
        .pc_we   (pc_we),
        .pc_nxt  (pc_nxt),
        .s_we    (s_we),
        .s_nxt   (s_nxt),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus responder and output monitor; everything here is sampled mid-cycle
    always @(negedge clk) begin
        cen = cen_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        din = 8'($urandom);
        if (rst) begin
            bus_ack = 1'b0;
            wcnt    = 0;
            hold    = 1'b0;
        end else begin
            if (hold && (bus_rd || bus_wr)) begin
                checks++;
                if (addr !== prev_addr) begin
                    errors++;
                    $display("FAIL addr_stable: addr=%h while held, required %h", addr, prev_addr);
                end
            end
            if (bus_rd || bus_wr) begin
                checks++;
                if (bus_rd && bus_wr) begin
                    errors++;
                    $display("FAIL rd_wr_excl: bus_rd=1 bus_wr=1, required at most one");
                end
                if (wcnt >= ack_delay && !(bus_wr && wr_stall)) begin
                    bus_ack = 1'b1;
                    if (bus_rd) din = mem[addr];
                end else begin
                    bus_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus_ack = 1'b0;
            end
            hold      = (bus_rd || bus_wr) && !(bus_ack && cen);
            prev_addr = addr;
            if (bus_ack && cen) begin
                act_bus.push_back({bus_wr, addr, bus_wr ? dout : din});
                wcnt = 0;
            end
            if (cen && pc_we) act_pc.push_back(pc_nxt);
            if (cen && s_we)  act_s.push_back(s_nxt);
            if (cen && done)  done_cnt++;
        end
    end

    task automatic start_op(input logic [7:0] o, input logic [15:0] p, input logic [15:0] sp,
                            input logic br, input bit tog);
        cen_toggle = 1'b0;
        @(negedge clk);
        op     = o;
        pc     = p;
        s      = sp;
        branch = br;
        start  = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        op         = 8'($urandom);
        pc         = 16'($urandom);
        cen_toggle = tog;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
        cen_toggle = 1'b0;
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus_rd, bus_wr, addr, dout, pc_we, pc_nxt, s_we, s_nxt, busy, done} !== 69'd0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b wr=%b addr=%h dout=%h pc_we=%b pc_nxt=%h s_we=%b s_nxt=%h busy=%b done=%b, required all 0",
                     bus_rd, bus_wr, addr, dout, pc_we, pc_nxt, s_we, s_nxt, busy, done);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || bus_rd !== 1'b0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b rd=%b done_cnt=%0d, required 0 0 0", busy, bus_rd, done_cnt);
        end
    endtask

    task automatic test_bra;
        bit ok; txn_t e, a; logic [15:0] ep, ap; int base;
        mem[16'h1000] = 8'h10;
        exp_bus.push_back({1'b0, 16'h1000, 8'h10});
        exp_pc.push_back(16'h1011);
        base = done_cnt; ack_delay = 1;
        start_op(OP_BRA, 16'h1000, 16'h0100, 1'b1, 1'b0);
        wait_done(base, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bra_timeout: done not seen, required done"); end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); checks++;
            if (act_bus.size() == 0) begin errors++; $display("FAIL bra_bus: no txn, required %h", e); end
            else begin a = act_bus.pop_front();
                if (a !== e) begin errors++; $display("FAIL bra_bus: got %h, required %h", a, e); end end
        end
        while (exp_pc.size() > 0) begin
            ep = exp_pc.pop_front(); checks++;
            if (act_pc.size() == 0) begin errors++; $display("FAIL bra_pc: no pc_we, required %h", ep); end
            else begin ap = act_pc.pop_front();
                if (ap !== ep) begin errors++; $display("FAIL bra_pc: got %h, required %h", ap, ep); end end
        end
        checks++;
        if (act_bus.size() != 0 || act_pc.size() != 0 || act_s.size() != 0 || done_cnt != base + 1) begin
            errors++;
            $display("FAIL bra_extra: bus=%0d pc=%0d s=%0d done=%0d, required 0 0 0 %0d",
                     act_bus.size(), act_pc.size(), act_s.size(), done_cnt, base + 1);
        end
        act_bus.delete(); act_pc.delete(); act_s.delete();
    endtask

    task automatic test_bne_untaken;
        bit ok; txn_t e, a; logic [15:0] ep, ap; int base;
        mem[16'h2000] = 8'h80;
`ifndef JTKCPU_BRA_FASTPATH_EN
        exp_bus.push_back({1'b0, 16'h2000, 8'h80});
`endif
        exp_pc.push_back(16'h2001);
        base = done_cnt; ack_delay = 0;
        start_op(OP_BNE, 16'h2000, 16'h0100, 1'b0, 1'b0);
        wait_done(base, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bne_timeout: done not seen, required done"); end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); checks++;
            if (act_bus.size() == 0) begin errors++; $display("FAIL bne_bus: no txn, required %h", e); end
            else begin a = act_bus.pop_front();
                if (a !== e) begin errors++; $display("FAIL bne_bus: got %h, required %h", a, e); end end
        end
        while (exp_pc.size() > 0) begin
            ep = exp_pc.pop_front(); checks++;
            if (act_pc.size() == 0) begin errors++; $display("FAIL bne_pc: no pc_we, required %h", ep); end
            else begin ap = act_pc.pop_front();
                if (ap !== ep) begin errors++; $display("FAIL bne_pc: got %h, required %h", ap, ep); end end
        end
        checks++;
        if (act_bus.size() != 0 || act_pc.size() != 0 || act_s.size() != 0 || done_cnt != base + 1) begin
            errors++;
            $display("FAIL bne_extra: bus=%0d pc=%0d s=%0d done=%0d, required 0 0 0 %0d",
                     act_bus.size(), act_pc.size(), act_s.size(), done_cnt, base + 1);
        end
        act_bus.delete(); act_pc.delete(); act_s.delete();
    endtask

    task automatic test_lbra_wrap;
        bit ok; txn_t e, a; logic [15:0] ep, ap; int base;
        mem[16'hFFFE] = 8'h00;
        mem[16'hFFFF] = 8'h05;
        exp_bus.push_back({1'b0, 16'hFFFE, 8'h00});
        exp_bus.push_back({1'b0, 16'hFFFF, 8'h05});
        exp_pc.push_back(16'h0005);
        base = done_cnt; ack_delay = 0;
        start_op(OP_LBRA, 16'hFFFE, 16'h0100, 1'b1, 1'b0);
        wait_done(base, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lbra_timeout: done not seen, required done"); end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); checks++;
            if (act_bus.size() == 0) begin errors++; $display("FAIL lbra_bus: no txn, required %h", e); end
            else begin a = act_bus.pop_front();
                if (a !== e) begin errors++; $display("FAIL lbra_bus: got %h, required %h", a, e); end end
        end
        while (exp_pc.size() > 0) begin
            ep = exp_pc.pop_front(); checks++;
            if (act_pc.size() == 0) begin errors++; $display("FAIL lbra_pc: no pc_we, required %h", ep); end
            else begin ap = act_pc.pop_front();
                if (ap !== ep) begin errors++; $display("FAIL lbra_pc: got %h, required %h", ap, ep); end end
        end
        checks++;
        if (act_bus.size() != 0 || act_pc.size() != 0 || act_s.size() != 0 || done_cnt != base + 1) begin
            errors++;
            $display("FAIL lbra_extra: bus=%0d pc=%0d s=%0d done=%0d, required 0 0 0 %0d",
                     act_bus.size(), act_pc.size(), act_s.size(), done_cnt, base + 1);
        end
        act_bus.delete(); act_pc.delete(); act_s.delete();
    endtask

    // Shared by the fast BSR and the slow, cen-toggling LBSR scenarios
    task automatic run_call(input string name, input logic [7:0] o, input logic [15:0] p,
                            input logic [15:0] sp, input int dly, input bit tog);
        bit ok; txn_t e, a; logic [15:0] ep, ap; int base;
        base = done_cnt; ack_delay = dly;
        start_op(o, p, sp, 1'b1, tog);
        wait_done(base, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_timeout: done not seen, required done", name); end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); checks++;
            if (act_bus.size() == 0) begin errors++; $display("FAIL %s_bus: no txn, required %h", name, e); end
            else begin a = act_bus.pop_front();
                if (a !== e) begin errors++; $display("FAIL %s_bus: got %h, required %h", name, a, e); end end
        end
        while (exp_pc.size() > 0) begin
            ep = exp_pc.pop_front(); checks++;
            if (act_pc.size() == 0) begin errors++; $display("FAIL %s_pc: no pc_we, required %h", name, ep); end
            else begin ap = act_pc.pop_front();
                if (ap !== ep) begin errors++; $display("FAIL %s_pc: got %h, required %h", name, ap, ep); end end
        end
        while (exp_s.size() > 0) begin
            ep = exp_s.pop_front(); checks++;
            if (act_s.size() == 0) begin errors++; $display("FAIL %s_s: no s_we, required %h", name, ep); end
            else begin ap = act_s.pop_front();
                if (ap !== ep) begin errors++; $display("FAIL %s_s: got %h, required %h", name, ap, ep); end end
        end
        checks++;
        if (act_bus.size() != 0 || act_pc.size() != 0 || act_s.size() != 0 || done_cnt != base + 1) begin
            errors++;
            $display("FAIL %s_extra: bus=%0d pc=%0d s=%0d done=%0d, required 0 0 0 %0d",
                     name, act_bus.size(), act_pc.size(), act_s.size(), done_cnt, base + 1);
        end
        act_bus.delete(); act_pc.delete(); act_s.delete();
    endtask

    task automatic test_bsr;
        mem[16'h3000] = 8'hFE;
        exp_bus.push_back({1'b0, 16'h3000, 8'hFE});
        exp_bus.push_back({1'b1, 16'h00FF, 8'h01});
        exp_bus.push_back({1'b1, 16'h00FE, 8'h30});
        exp_pc.push_back(16'h2FFF);
        exp_s.push_back(16'h00FE);
        run_call("bsr", OP_BSR, 16'h3000, 16'h0100, 0, 1'b0);
    endtask

    task automatic test_lbsr_slow;
        mem[16'h4000] = 8'h01;
        mem[16'h4001] = 8'h00;
        exp_bus.push_back({1'b0, 16'h4000, 8'h01});
        exp_bus.push_back({1'b0, 16'h4001, 8'h00});
        exp_bus.push_back({1'b1, 16'h01FF, 8'h02});
        exp_bus.push_back({1'b1, 16'h01FE, 8'h40});
        exp_pc.push_back(16'h4102);
        exp_s.push_back(16'h01FE);
        run_call("lbsr", OP_LBSR, 16'h4000, 16'h0200, 3, 1'b1);
    endtask

    task automatic test_back_to_back;
        bit ok1, ok2; txn_t e, a; logic [15:0] ep, ap; int base;
        mem[16'h5000] = 8'h7F;
        mem[16'h6000] = 8'hF0;
`ifndef JTKCPU_BRA_FASTPATH_EN
        exp_bus.push_back({1'b0, 16'h5000, 8'h7F});
`endif
        exp_bus.push_back({1'b0, 16'h6000, 8'hF0});
        exp_pc.push_back(16'h5001);
        exp_pc.push_back(16'h5FF1);
        base = done_cnt; ack_delay = 0;
        start_op(OP_BRN, 16'h5000, 16'h0100, 1'b0, 1'b0);
        start_op(OP_BRA, 16'h5800, 16'h0100, 1'b1, 1'b0);
        wait_done(base, ok1);
        start_op(OP_BEQ, 16'h6000, 16'h0100, 1'b1, 1'b0);
        wait_done(base + 1, ok2);
        checks++;
        if (!ok1 || !ok2) begin errors++; $display("FAIL b2b_timeout: done seen %b %b, required 1 1", ok1, ok2); end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); checks++;
            if (act_bus.size() == 0) begin errors++; $display("FAIL b2b_bus: no txn, required %h", e); end
            else begin a = act_bus.pop_front();
                if (a !== e) begin errors++; $display("FAIL b2b_bus: got %h, required %h", a, e); end end
        end
        while (exp_pc.size() > 0) begin
            ep = exp_pc.pop_front(); checks++;
            if (act_pc.size() == 0) begin errors++; $display("FAIL b2b_pc: no pc_we, required %h", ep); end
            else begin ap = act_pc.pop_front();
                if (ap !== ep) begin errors++; $display("FAIL b2b_pc: got %h, required %h", ap, ep); end end
        end
        checks++;
        if (act_bus.size() != 0 || act_pc.size() != 0 || act_s.size() != 0 || done_cnt != base + 2) begin
            errors++;
            $display("FAIL b2b_extra: bus=%0d pc=%0d s=%0d done=%0d, required 0 0 0 %0d",
                     act_bus.size(), act_pc.size(), act_s.size(), done_cnt, base + 2);
        end
        act_bus.delete(); act_pc.delete(); act_s.delete();
    endtask

    task automatic test_rst_mid;
        bit seen, ok; txn_t e, a; logic [15:0] ep, ap; int base;
        mem[16'h7000] = 8'h02;
        exp_bus.push_back({1'b0, 16'h7000, 8'h02});
        exp_pc.push_back(16'h7003);
        base = done_cnt; ack_delay = 0; wr_stall = 1'b1;
        start_op(OP_BSR, 16'h7000, 16'h0400, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (bus_wr) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_push_timeout: bus_wr never seen, required 1"); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({bus_rd, bus_wr, addr, dout, pc_we, pc_nxt, s_we, s_nxt, busy, done} !== 69'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: rd=%b wr=%b addr=%h dout=%h pc_we=%b s_we=%b busy=%b done=%b, required all 0",
                     bus_rd, bus_wr, addr, dout, pc_we, s_we, busy, done);
        end
        rst = 1'b0;
        wr_stall = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); checks++;
            if (act_bus.size() == 0) begin errors++; $display("FAIL rst_bus: no txn, required %h", e); end
            else begin a = act_bus.pop_front();
                if (a !== e) begin errors++; $display("FAIL rst_bus: got %h, required %h", a, e); end end
        end
        while (exp_pc.size() > 0) begin
            ep = exp_pc.pop_front(); checks++;
            if (act_pc.size() == 0) begin errors++; $display("FAIL rst_pc: no pc_we, required %h", ep); end
            else begin ap = act_pc.pop_front();
                if (ap !== ep) begin errors++; $display("FAIL rst_pc: got %h, required %h", ap, ep); end end
        end
        checks++;
        if (act_bus.size() != 0 || act_s.size() != 0 || done_cnt != base || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_push: bus=%0d s_we=%0d done=%0d busy=%b, required 0 0 %0d 0",
                     act_bus.size(), act_s.size(), done_cnt, busy, base);
        end
        act_bus.delete(); act_pc.delete(); act_s.delete();
        // The sequencer must accept a fresh branch straight after the aborted call
        mem[16'h7100] = 8'h01;
        base = done_cnt;
        start_op(OP_BRA, 16'h7100, 16'h0400, 1'b1, 1'b0);
        wait_done(base, ok);
        checks++;
        if (!ok || act_pc.size() != 1) begin
            errors++;
            $display("FAIL rst_recover: done=%b pc_we count=%0d, required 1 1", ok, act_pc.size());
        end else begin
            ap = act_pc.pop_front(); checks++;
            if (ap !== 16'h7102) begin errors++; $display("FAIL rst_recover_pc: got %h, required 7102", ap); end
        end
        act_bus.delete(); act_pc.delete(); act_s.delete();
    endtask

    initial begin
        checks = 0; errors = 0; done_cnt = 0; ack_delay = 0; wcnt = 0;
        cen_toggle = 1'b0; wr_stall = 1'b0; hold = 1'b0; prev_addr = 16'd0;
        rst = 1'b1; cen = 1'b1; start = 1'b0; op = 8'd0; branch = 1'b0;
        pc = 16'd0; s = 16'd0; din = 8'd0; bus_ack = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
        test_reset;
        test_bra;
        test_bne_untaken;
        test_lbra_wrap;
        test_bsr;
        test_lbsr_slow;
        test_back_to_back;
        test_rst_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
